// File: rtl/eva_sort_pkg.sv
// Definitions shared between the EVA argsort sequencer and the argsort gather unit:
// the width of an element index and the 2-bit state encoding.
package eva_sort_pkg;

    localparam int IDX_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/eva_sel_n.sv
// N-to-1 selector of W-bit lanes from a flat vector. A select value of N or
// more produces zero.
module eva_sel_n
    import eva_sort_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 18
) (
    input  logic [W*N-1:0]   i_data,
    input  logic [IDX_W-1:0] i_sel,
    output logic [W-1:0]     o_data
);

    // A compare against every lane keeps out-of-range selects at zero
    // without a separate range check.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == IDX_W'(i)) begin
                o_data = i_data[W*i +: W];
            end
        end
    end

endmodule

// File: rtl/eva_argsort_gather.sv
// Captures a vector and its argsort result, then streams the values out in
// sorted order with their original indices. Optional macro EVA_GATHER_RANK_EN
// adds the rank_1D output (inverse permutation).
module eva_argsort_gather
    import eva_sort_pkg::*;
#(
    parameter int bit_len = 18,
    parameter int Number  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [bit_len*Number-1:0] in,
    input  logic [IDX_W*Number-1:0]   sorted_index_1D,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [bit_len-1:0]        out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      busy,
`ifdef EVA_GATHER_RANK_EN
    output logic                      done,
    output logic [IDX_W*Number-1:0]   rank_1D
`else
    output logic                      done
`endif
);

    localparam int              POS_W    = (Number > 1) ? $clog2(Number) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(Number - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [POS_W-1:0]          r_pos;
    logic [bit_len*Number-1:0] r_data_q;
    logic [IDX_W-1:0]          r_idx_q [Number];

    logic [IDX_W-1:0]   w_cur_idx;
    logic [bit_len-1:0] w_sel_data;
    logic               w_last;
    logic               w_capture;
    logic               w_xfer;

    assign w_cur_idx = r_idx_q[r_pos];
    assign w_last    = (r_pos == LAST_POS);
    assign w_capture = (r_state == ST_IDLE) && start;
    assign w_xfer    = (r_state == ST_STREAM) && out_ready;

    eva_sel_n #(
        .N (Number),
        .W (bit_len)
    ) u_sel (
        .i_data (r_data_q),
        .i_sel  (w_cur_idx),
        .o_data (w_sel_data)
    );

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first, so no branch leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_LOAD;
            ST_LOAD:   w_next_state = ST_STREAM;
            ST_STREAM: if (w_xfer && w_last) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are gated by state so they read zero outside STREAM.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_LOAD: busy = 1'b1;
            ST_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = w_sel_data;
                out_index = w_cur_idx;
                out_last  = w_last;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the small index array is reset so outputs are defined straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos    <= '0;
            r_data_q <= '0;
            for (int i = 0; i < Number; i++) r_idx_q[i] <= '0;
        end else if (w_capture) begin
            r_pos    <= '0;
            r_data_q <= in;
            for (int i = 0; i < Number; i++) r_idx_q[i] <= sorted_index_1D[IDX_W*i +: IDX_W];
        end else if (w_xfer && !w_last) begin
            r_pos <= r_pos + 1'b1;
        end
    end

`ifdef EVA_GATHER_RANK_EN
    logic [IDX_W-1:0] r_rank_q [Number];

    // Each transfer records the stream position against the original index;
    // an out-of-range index matches no entry and writes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Number; i++) r_rank_q[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < Number; i++) r_rank_q[i] <= '0;
        end else if (w_xfer) begin
            for (int i = 0; i < Number; i++) begin
                if (w_cur_idx == IDX_W'(i)) r_rank_q[i] <= IDX_W'(r_pos);
            end
        end
    end

    always_comb begin
        rank_1D = '0;
        for (int i = 0; i < Number; i++) rank_1D[IDX_W*i +: IDX_W] = r_rank_q[i];
    end
`endif

endmodule

// File: tb/tb_eva_argsort_gather.sv
// Scoreboard bench for eva_argsort_gather: directed streams with stalls, ignored
// starts, mid-stream reset and (with EVA_GATHER_RANK_EN) the rank output.
module tb_eva_argsort_gather;

    localparam int BL = 18;
    localparam int N  = 16;

    typedef struct packed {
        logic [BL-1:0] d;
        logic [3:0]    i;
        logic          l;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BL*N-1:0] tb_in;
    logic [4*N-1:0]  tb_idx;
    logic            out_valid;
    logic            out_ready;
    logic [BL-1:0]   out_data;
    logic [3:0]      out_index;
    logic            out_last;
    logic            busy;
    logic            done;
`ifdef EVA_GATHER_RANK_EN
    logic [4*N-1:0]  rank_1D;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t hold;
    bit   hold_vld = 1'b0;

    eva_argsort_gather #(.bit_len(BL), .Number(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in              (tb_in),
        .sorted_index_1D (tb_idx),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_last        (out_last),
        .busy            (busy),
`ifdef EVA_GATHER_RANK_EN
        .done            (done),
        .rank_1D         (rank_1D)
`else
        .done            (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    // Model: slot p presents index tb_idx[p] and value tb_in[index].
    task automatic push_expected();
        exp_t       e;
        logic [3:0] ix;
        for (int p = 0; p < N; p++) begin
            ix  = tb_idx[4*p +: 4];
            e.i = ix;
            e.d = tb_in[BL*ix +: BL];
            e.l = (p == N - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: compares each accepted element, and checks outputs hold during stalls.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (hold_vld) begin
                check("stall_data", out_data, hold.d);
                check("stall_index", out_index, hold.i);
                check("stall_last", out_last, hold.l);
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("expected_entry_for_transfer");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_index", out_index, e.i);
                    check("out_last", out_last, e.l);
                end
                hold_vld = 1'b0;
            end else begin
                hold     = '{d: out_data, i: out_index, l: out_last};
                hold_vld = 1'b1;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Start is sampled at the second edge (edge T); returns just after T.
    task automatic start_capture();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // k counts negedges after edge T; k=0 is the LOAD cycle.
    task automatic wait_done(input bit rnd, input bit timing, input bit pulse,
                             input int budget, output int k);
        bit seen;
        seen = 1'b0;
        k    = 0;
        while (k <= budget) begin
            @(negedge clk);
            if (timing && k == 0) begin
                check("load_busy", busy, 1);
                check("load_valid", out_valid, 0);
            end
            if (timing && k == 1) check("stream_valid", out_valid, 1);
            if (done) begin
                seen = 1'b1;
                check("done_busy", busy, 0);
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (pulse) begin
                start = (k == 3 || k == 10);
                if (start) begin
                    tb_in  = '1;
                    tb_idx = '0;
                end
            end
            k++;
        end
        if (!seen) fail_now("done_timeout");
    endtask

    task automatic load_ramp_reversed();
        for (int k = 0; k < N; k++) begin
            tb_in[BL*k +: BL] = BL'(k * 3);
            tb_idx[4*k +: 4]  = 4'(N - 1 - k);
        end
    endtask

    initial begin
        int k;
        int dones;

        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        load_ramp_reversed();

        // Reset state, with start held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy_after_rst", busy, 0);
        check("idle_valid_after_rst", out_valid, 0);

        // Reversed ramp, ready held high
        push_expected();
        start_capture();
        wait_done(1'b0, 1'b1, 1'b0, 40, k);
        check("done_cycle", k, N + 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("sb_drained_a", sb.size(), 0);

        // Same stimulus with random backpressure
        push_expected();
        start_capture();
        wait_done(1'b1, 1'b0, 1'b0, 800, k);
        check("sb_drained_b", sb.size(), 0);
        out_ready = 1'b1;

        // Start pulses mid-stream must not re-capture
        for (int p = 0; p < N; p++) begin
            tb_in[BL*p +: BL] = BL'(100 + 7 * p);
            tb_idx[4*p +: 4]  = 4'((p * 5) % N);
        end
        push_expected();
        start_capture();
        wait_done(1'b0, 1'b0, 1'b1, 40, k);
        start = 1'b0;
        check("done_cycle_pulsed", k, N + 1);
        check("sb_drained_c", sb.size(), 0);

        // Reset while pos=7 is presented
        load_ramp_reversed();
        push_expected();
        start_capture();
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", out_data, 0);
        check("midrst_index", out_index, 0);
        check("midrst_consumed", sb.size(), N - 7);
        sb.delete();
        dones = 0;
        repeat (3) @(negedge clk) if (done) dones++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk) if (done) dones++;
        check("midrst_no_done", dones, 0);

        push_expected();
        start_capture();
        wait_done(1'b0, 1'b1, 1'b0, 40, k);
        check("done_cycle_after_rst", k, N + 1);
        check("sb_drained_d", sb.size(), 0);

`ifdef EVA_GATHER_RANK_EN
        begin
            logic [3:0] perm [N];
            logic [3:0] inv  [N];
            for (int g = 0; g < N / 4; g++) begin
                perm[4*g + 0] = 4'(4*g + 2);
                perm[4*g + 1] = 4'(4*g + 0);
                perm[4*g + 2] = 4'(4*g + 3);
                perm[4*g + 3] = 4'(4*g + 1);
            end
            for (int p = 0; p < N; p++) begin
                tb_idx[4*p +: 4]  = perm[p];
                inv[perm[p]]      = 4'(p);
                tb_in[BL*p +: BL] = BL'(p + 1);
            end
            push_expected();
            start_capture();
            wait_done(1'b0, 1'b0, 1'b0, 40, k);
            for (int i = 0; i < N; i++) check("rank", rank_1D[4*i +: 4], inv[i]);
            check("sb_drained_e", sb.size(), 0);
        end
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
